// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed-latency backing RAM, valid/ready on both sides.
// Define DMEM_MISALIGN_CHECK_EN to report misaligned halfword/word accesses as errors instead of force-aligning.
module dmem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    weReg;
  logic [ADDR_WIDTH-1:0]   addrReg;
  logic [31:0]             wdataReg;
  logic [2:0]              funct3Reg;

  logic [31:0]             mem [WORDS];

  logic [ADDR_WIDTH-3:0]   wordIdx;
  logic [31:0]             memWord;
  logic [4:0]              byteShift;
  logic [7:0]              byteVal;
  logic [15:0]             halfVal;
  logic                    illegal;
  logic                    misalign;
  logic                    accErr;
  logic [31:0]             loadData;
  logic [3:0]              byteEn;
  logic [31:0]             wrData;
  logic                    commit;
  logic                    memWe;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH];

  assign wordIdx   = addrReg[ADDR_WIDTH-1:2];
  assign memWord   = mem[wordIdx];
  assign byteShift = {addrReg[1:0], 3'b000};
  assign byteVal   = 8'(memWord >> byteShift);
  assign halfVal   = addrReg[1] ? memWord[31:16] : memWord[15:0];
  assign commit    = (state == ACCESS) && (cnt == 4'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    illegal  = 1'b0;
    misalign = 1'b0;
    loadData = '0;
    byteEn   = '0;
    wrData   = '0;

    if (weReg) illegal = funct3Reg[2] || (funct3Reg[1:0] == 2'b11);
    else       illegal = (funct3Reg == 3'b011) || (funct3Reg[2:1] == 2'b11);

`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((funct3Reg[1:0] == 2'b01) && addrReg[0]) ||
               ((funct3Reg[1:0] == 2'b10) && (addrReg[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    accErr = illegal || misalign;

    case (funct3Reg)
      3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
      3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
      3'b010:  loadData = memWord;
      3'b100:  loadData = {24'd0, byteVal};
      3'b101:  loadData = {16'd0, halfVal};
      default: loadData = '0;
    endcase

    case (funct3Reg[1:0])
      2'b00: begin
        byteEn = 4'b0001 << addrReg[1:0];
        wrData = {4{wdataReg[7:0]}};
      end
      2'b01: begin
        byteEn = addrReg[1] ? 4'b1100 : 4'b0011;
        wrData = {2{wdataReg[15:0]}};
      end
      2'b10: begin
        byteEn = 4'b1111;
        wrData = wdataReg;
      end
      default: begin
        byteEn = 4'b0000;
        wrData = '0;
      end
    endcase
  end

  assign memWe = commit && weReg && !accErr && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      weReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      funct3Reg <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weReg     <= req_we;
            addrReg   <= req_addr[ADDR_WIDTH-1:0];
            wdataReg  <= req_wdata;
            funct3Reg <= req_funct3;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            rsp_rdata <= (weReg || accErr) ? '0 : loadData;
            rsp_err   <= accErr;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents must survive rst and a reset would bar RAM inference.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-level memory model plus a per-cycle compare process.
module tb_dmem_responder;

  localparam int ADDR_WIDTH = 17;
  localparam int LATENCY    = 2;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int          total  = 0;
  int          passed = 0;
  bit          modelBusy = 1'b0;
  bit          expValid  = 1'b0;
  logic [31:0] expRdata  = '0;
  logic        expErr    = 1'b0;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic [7:0]  mdl [int];

  dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [7:0] rd_byte(input int k);
    return mdl.exists(k) ? mdl[k] : 8'h00;
  endfunction

  // Byte-addressed view of the RAM; sizes come straight from funct3[1:0].
  function automatic void model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [2:0] f3, input bit doCommit,
                                       output logic [31:0] rdata, output logic err);
    int a, nb, base;
    bit legal, mis;
    logic [31:0] v;
    a  = int'(addr[ADDR_WIDTH-1:0]);
    nb = 1 << f3[1:0];
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (a % nb) != 0;
`endif
    rdata = '0;
    err   = !legal || mis;
    if (err) return;
    base = a - (a % nb);
    if (we) begin
      if (doCommit) for (int i = 0; i < nb; i++) mdl[base + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rd_byte(base + i);
      if (!f3[2] && nb < 4 && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      rdata = v;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("busy", busy, modelBusy);
      check("req_ready", req_ready, !modelBusy);
      if (modelBusy && expValid && rsp_valid) begin
        check("rsp_rdata", rsp_rdata, expRdata);
        check("rsp_err", rsp_err, expErr);
      end
    end
  end

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input bit doCommit);
    int n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout_fail("req_accept");
    @(posedge clk);
    model_access(we, addr, wdata, f3, doCommit, expRdata, expErr);
    expValid = 1'b1;
    modelBusy = 1'b1;
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    if (!rsp_valid) timeout_fail("rsp_valid");
    else check("latency", n - 1, LATENCY);
    lastRdata = rsp_rdata;
    lastErr   = rsp_err;
  endtask

  task automatic take_rsp(input int hold);
    repeat (hold) begin
      check("rsp_hold_valid", rsp_valid, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    modelBusy = 1'b0;
    expValid  = 1'b0;
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    send_req(we, addr, wdata, f3, 1'b1);
    wait_rsp();
    take_rsp(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // Store then load a full word.
    txn(1'b1, 32'h100, 32'hDEADBEEF, F_W);
    check("t1_sw_rdata", lastRdata, 32'h0);
    txn(1'b0, 32'h100, 32'h0, F_W);
    check("t1_lw", lastRdata, 32'hDEADBEEF);
    check("t1_lw_err", lastErr, 0);

    // Byte store into the top lane, signed/unsigned byte loads.
    txn(1'b1, 32'h100, 32'h11223344, F_W);
    txn(1'b1, 32'h103, 32'h00000080, F_B);
    txn(1'b0, 32'h100, 32'h0, F_W);
    check("t2_lw", lastRdata, 32'h80223344);
    txn(1'b0, 32'h103, 32'h0, F_B);
    check("t2_lb", lastRdata, 32'hFFFFFF80);
    txn(1'b0, 32'h103, 32'h0, F_BU);
    check("t2_lbu", lastRdata, 32'h00000080);

    // Halfword store into the upper half.
    txn(1'b1, 32'h102, 32'h0000A5A5, F_H);
    txn(1'b0, 32'h102, 32'h0, F_H);
    check("t3_lh", lastRdata, 32'hFFFFA5A5);
    txn(1'b0, 32'h102, 32'h0, F_HU);
    check("t3_lhu", lastRdata, 32'h0000A5A5);
    txn(1'b0, 32'h100, 32'h0, F_W);
    check("t3_lw", lastRdata, 32'hA5A53344);

    // Response backpressure with a second request waiting.
    send_req(1'b0, 32'h100, 32'h0, F_W, 1'b1);
    wait_rsp();
    req_we = 1'b0; req_addr = 32'h103; req_wdata = '0; req_funct3 = F_BU; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hA5A53344);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    modelBusy = 1'b0; expValid = 1'b0;
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", req_ready, 1);
    check("bp_rsp_cleared", rsp_valid, 0);
    @(posedge clk);
    model_access(1'b0, 32'h103, 32'h0, F_BU, 1'b1, expRdata, expErr);
    expValid = 1'b1; modelBusy = 1'b1;
    #1 req_valid = 1'b0;
    wait_rsp();
    check("bp_second_lbu", lastRdata, 32'h000000A5);
    take_rsp(0);

    // Reset during ACCESS discards the pending store.
    txn(1'b1, 32'h200, 32'h0, F_W);
    send_req(1'b1, 32'h200, 32'h55555555, F_W, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    modelBusy = 1'b0; expValid = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_rdata", rsp_rdata, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h200, 32'h0, F_W);
    check("t5_lw_discarded", lastRdata, 32'h0);

    // Illegal funct3 and misaligned word load.
    txn(1'b0, 32'h100, 32'h0, 3'b011);
    check("t6_illegal_rdata", lastRdata, 32'h0);
    check("t6_illegal_err", lastErr, 1);
    txn(1'b0, 32'h102, 32'h0, F_W);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("t6_mis_rdata", lastRdata, 32'h0);
    check("t6_mis_err", lastErr, 1);
`else
    check("t6_mis_rdata", lastRdata, 32'hA5A53344);
    check("t6_mis_err", lastErr, 0);
`endif
    txn(1'b1, 32'h100, 32'hFFFFFFFF, 3'b011);
    check("t6_ill_store_err", lastErr, 1);
    txn(1'b0, 32'h100, 32'h0, F_W);
    check("t6_ill_store_nowrite", lastRdata, 32'hA5A53344);

    // Address bits above ADDR_WIDTH wrap.
    txn(1'b1, 32'h00020104, 32'hCAFEF00D, F_W);
    txn(1'b0, 32'h104, 32'h0, F_W);
    check("wrap_lw", lastRdata, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
